// File: rtl/ika9958_pkg.sv
// Shared types and constants for the IKA9958 clock-phase generator.
package ika9958_pkg;

    typedef enum logic {
        CM_MASTER = 1'b0,
        CM_SLAVE  = 1'b1
    } clk_mode_t;

    localparam logic [1:0] P_DLFALL    = 2'd0;
    localparam logic [1:0] P_IDLE      = 2'd3;
    localparam logic [1:0] STRETCH_MAX = 2'd3;

endpackage

// File: rtl/ika9958_sync2.sv
// Two-flop synchroniser with asynchronous clear to a configurable level.
module ika9958_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/ika9958_clkgen.sv
// DHCLK/DLCLK phase divider with optional slave lock to an external DLCLK,
// plus generation of the synchronised VDP system reset.
module ika9958_clkgen
    import ika9958_pkg::*;
#(
    parameter int CM     = 0,
    parameter int LOCK_N = 4
) (
    input  logic i_XTAL1,
    input  logic i_RST_n,
    input  logic i_XTAL_NCEN,
    input  logic i_DLCLK_n,
    output logic o_DHCLK_n,
    output logic o_DLCLK_n,
    output logic o_DHCLK_NCEN,
    output logic o_DLCLK_NCEN,
    output logic o_LOCKED,
    output logic o_SYSRST_n
);

    localparam clk_mode_t  MODE   = (CM != 0) ? CM_SLAVE : CM_MASTER;
    localparam logic [3:0] LOCK_V = 4'(LOCK_N);

    logic       rstSync;
    logic       dlSync;
    logic       tick;
    logic       edgeDet;
    logic       realign;

    logic [1:0] phase_q,      phase_d;
    logic       dhNcen_q,     dhNcen_d;
    logic       dlNcen_q,     dlNcen_d;
    logic       locked_q,     locked_d;
    logic       sysRst_q,     sysRst_d;
    logic       dlHist_q;
    logic       pend_q,       pend_d;
    logic [3:0] lockCnt_q,    lockCnt_d;
    logic [1:0] stretchCnt_q, stretchCnt_d;

    ika9958_sync2 #(.RST_VAL(1'b0)) u_rst_sync (
        .clk_i   (i_XTAL1),
        .rst_n_i (i_RST_n),
        .d_i     (1'b1),
        .q_o     (rstSync)
    );

    ika9958_sync2 #(.RST_VAL(1'b0)) u_dl_sync (
        .clk_i   (i_XTAL1),
        .rst_n_i (i_RST_n),
        .d_i     (i_DLCLK_n),
        .q_o     (dlSync)
    );

    always_comb begin
        tick    = i_XTAL_NCEN;
        edgeDet = dlHist_q & ~dlSync;
        // A falling edge seen on the same cycle as a tick is consumed directly.
        realign = (MODE == CM_SLAVE) && tick && (pend_q || edgeDet);

        phase_d      = phase_q;
        pend_d       = pend_q;
        lockCnt_d    = lockCnt_q;
        stretchCnt_d = stretchCnt_q;
        locked_d     = locked_q;
        sysRst_d     = sysRst_q;
        dlNcen_d     = 1'b0;

        if (MODE == CM_MASTER) begin
            pend_d = 1'b0;
            if (tick && rstSync) begin
                phase_d  = phase_q + 2'd1;
                dlNcen_d = (phase_q == P_IDLE);
                if (phase_q == P_IDLE) begin
                    sysRst_d = 1'b1;
                end
            end
            locked_d = sysRst_d;
        end else begin
            pend_d = tick ? 1'b0 : (pend_q | edgeDet);
            if (realign) begin
                phase_d      = P_DLFALL;
                dlNcen_d     = 1'b1;
                stretchCnt_d = 2'd0;
                if (phase_q == P_IDLE) begin
                    lockCnt_d = (lockCnt_q >= LOCK_V) ? LOCK_V : lockCnt_q + 4'd1;
                end else begin
                    lockCnt_d = 4'd0;
                end
                if (rstSync && (lockCnt_q == LOCK_V)) begin
                    sysRst_d = 1'b1;
                end
            end else if (tick) begin
                if (phase_q != P_IDLE) begin
                    phase_d = phase_q + 2'd1;
                end else begin
                    // Waiting at the idle phase for a late external edge.
                    if (stretchCnt_q != STRETCH_MAX) begin
                        stretchCnt_d = stretchCnt_q + 2'd1;
                    end
                    if (stretchCnt_d == STRETCH_MAX) begin
                        lockCnt_d = 4'd0;
                    end
                end
            end
            // Lock is only claimed on a realign that finds the counter already full,
            // but it is dropped on the very tick the counter is cleared.
            if (lockCnt_d != LOCK_V) begin
                locked_d = 1'b0;
            end else if (realign) begin
                locked_d = (lockCnt_q == LOCK_V);
            end
        end

        dhNcen_d = tick && phase_q[0] && !phase_d[0];
    end

    always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
        if (!i_RST_n) begin
            phase_q      <= P_IDLE;
            dhNcen_q     <= 1'b0;
            dlNcen_q     <= 1'b0;
            locked_q     <= 1'b0;
            sysRst_q     <= 1'b0;
            dlHist_q     <= 1'b0;
            pend_q       <= 1'b0;
            lockCnt_q    <= 4'd0;
            stretchCnt_q <= 2'd0;
        end else begin
            phase_q      <= phase_d;
            dhNcen_q     <= dhNcen_d;
            dlNcen_q     <= dlNcen_d;
            locked_q     <= locked_d;
            sysRst_q     <= sysRst_d;
            dlHist_q     <= dlSync;
            pend_q       <= pend_d;
            lockCnt_q    <= lockCnt_d;
            stretchCnt_q <= stretchCnt_d;
        end
    end

    assign o_DHCLK_n    = phase_q[0];
    assign o_DLCLK_n    = phase_q[1];
    assign o_DHCLK_NCEN = dhNcen_q;
    assign o_DLCLK_NCEN = dlNcen_q;
    assign o_LOCKED     = locked_q;
    assign o_SYSRST_n   = sysRst_q;

endmodule
